// File: rtl/updn_counter_mod.sv
// Parametrised up/down counter with programmable terminal value, wrap/saturate
// select, sticky overflow flag and 74169-style active-low control set.
module updn_counter_mod #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             CLK,
   input  logic             RSTB,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] LIMIT,
   input  logic             U_DB,
   input  logic             ENPB,
   input  logic             ENTB,
   input  logic             LOADB,
   input  logic             SATB,
   input  logic             CLRFLGB,
   output logic [WIDTH-1:0] Q,
   output logic             RCOB,
   output logic             OVF
);

   logic             tc;
   logic             cnt;
   logic [WIDTH-1:0] q_next;
   logic             ovf_next;

   // Up-count terminal uses >= so a loaded value above LIMIT still terminates.
   assign tc   = U_DB ? (Q >= LIMIT) : (Q == '0);
   assign cnt  = !ENPB && !ENTB && LOADB;
   assign RCOB = !(tc && !ENTB);

   always_comb begin
      q_next   = Q;
      ovf_next = OVF && CLRFLGB;
      if (!LOADB) begin
         q_next = A;
      end else if (cnt) begin
         if (!tc) begin
            q_next = U_DB ? Q + 1'b1 : Q - 1'b1;
         end else if (SATB) begin
            q_next = U_DB ? '0 : LIMIT;
         end
      end
      if (cnt && tc) begin
         ovf_next = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTB) begin
         Q   <= RESET_VAL;
         OVF <= 1'b0;
      end else begin
         Q   <= q_next;
         OVF <= ovf_next;
      end
   end

endmodule

// File: tb/tb_updn_counter_mod.sv
// Bench for updn_counter_mod: directed scenarios plus a random phase, all
// checked against an arithmetic reference model; also a two-stage cascade.
module tb_updn_counter_mod;

   logic       clk = 1'b0;
   logic       rstb, u_db, enpb, entb, loadb, satb, clrflgb;
   logic [7:0] a, limit;
   logic [7:0] q;
   logic       rcob, ovf;

   logic       c_udb, c_enpb, c_entb, c_loadb;
   logic [7:0] c_a;
   logic [3:0] lo_q, hi_q;
   logic       lo_rcob, hi_rcob, lo_ovf, hi_ovf;

   int errors = 0;
   int checks = 0;
   int m_q;
   bit m_ovf;

   always #5 clk = ~clk;

   updn_counter_mod #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
      .CLK(clk), .RSTB(rstb), .A(a), .LIMIT(limit), .U_DB(u_db), .ENPB(enpb),
      .ENTB(entb), .LOADB(loadb), .SATB(satb), .CLRFLGB(clrflgb),
      .Q(q), .RCOB(rcob), .OVF(ovf)
   );

   updn_counter_mod #(.WIDTH(4), .RESET_VAL(4'h0)) lo (
      .CLK(clk), .RSTB(rstb), .A(c_a[3:0]), .LIMIT(4'hF), .U_DB(c_udb), .ENPB(c_enpb),
      .ENTB(c_entb), .LOADB(c_loadb), .SATB(1'b1), .CLRFLGB(1'b1),
      .Q(lo_q), .RCOB(lo_rcob), .OVF(lo_ovf)
   );

   updn_counter_mod #(.WIDTH(4), .RESET_VAL(4'h0)) hi (
      .CLK(clk), .RSTB(rstb), .A(c_a[7:4]), .LIMIT(4'hF), .U_DB(c_udb), .ENPB(c_enpb),
      .ENTB(lo_rcob), .LOADB(c_loadb), .SATB(1'b1), .CLRFLGB(1'b1),
      .Q(hi_q), .RCOB(hi_rcob), .OVF(hi_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_tc();
      return u_db ? (m_q >= int'(limit)) : (m_q == 0);
   endfunction

   function automatic logic exp_rcob();
      return !(model_tc() && !entb);
   endfunction

   // Reference: one rising edge applied to the abstract counter value.
   task automatic model_edge();
      bit run, term;
      if (!rstb) begin
         m_q = 0;
         m_ovf = 0;
      end else begin
         run  = !enpb && !entb && loadb;
         term = model_tc();
         if (!clrflgb) m_ovf = 0;
         if (run && term) m_ovf = 1;
         if (!loadb) m_q = int'(a);
         else if (run) begin
            if (!term) m_q = u_db ? m_q + 1 : m_q - 1;
            else if (satb) m_q = u_db ? 0 : int'(limit);
         end
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      chk({tag, ".q"}, 32'(q), 32'(m_q));
      chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
      chk({tag, ".rcob"}, 32'(rcob), 32'(exp_rcob()));
   endtask

   initial begin
      c_udb = 1'b1; c_enpb = 1'b1; c_entb = 1'b0; c_loadb = 1'b1; c_a = 8'h00;
      m_q = 0; m_ovf = 0;

      // Reset wins over a simultaneous load
      rstb = 0; loadb = 0; a = 8'h55; limit = 8'd9; u_db = 1; enpb = 1; entb = 1;
      satb = 1; clrflgb = 1;
      tick("reset");
      chk("reset_q", 32'(q), 32'h00);
      chk("reset_ovf", 32'(ovf), 32'h0);
      rstb = 1; loadb = 1;
      tick("hold");
      chk("hold_q", 32'(q), 32'h00);

      // Up wrap at LIMIT=9
      enpb = 0; entb = 0;
      for (int i = 0; i < 9; i++) tick("up");
      chk("up_at9_q", 32'(q), 32'd9);
      chk("up_at9_rcob", 32'(rcob), 32'h0);
      tick("wrap");
      chk("wrap_q", 32'(q), 32'd0);
      chk("wrap_ovf", 32'(ovf), 32'h1);
      chk("wrap_rcob", 32'(rcob), 32'h1);

      // Down saturate from 2
      satb = 0; u_db = 0; loadb = 0; a = 8'd2; clrflgb = 0;
      tick("ld2");
      chk("ld2_q", 32'(q), 32'd2);
      chk("ld2_ovf", 32'(ovf), 32'h0);
      loadb = 1; clrflgb = 1;
      tick("dn1");
      tick("dn0");
      chk("dn0_q", 32'(q), 32'd0);
      chk("dn0_ovf", 32'(ovf), 32'h0);
      chk("dn0_rcob", 32'(rcob), 32'h0);
      tick("dnsat");
      chk("dnsat_q", 32'(q), 32'd0);
      chk("dnsat_ovf", 32'(ovf), 32'h1);
      entb = 1;
      #1 chk("entb_rcob", 32'(rcob), 32'h1);
      tick("entb_hold");
      chk("entb_hold_q", 32'(q), 32'd0);

      // Flag clear without TC
      entb = 0; enpb = 1; clrflgb = 0;
      tick("clr");
      chk("clr_ovf", 32'(ovf), 32'h0);
      clrflgb = 1; enpb = 0;

      // Load priority and out-of-range values
      satb = 1; u_db = 1; loadb = 0; a = 8'hF0;
      tick("ldf0");
      chk("ldf0_q", 32'(q), 32'hF0);
      chk("ldf0_ovf", 32'(ovf), 32'h0);
      loadb = 1;
      tick("oor_up");
      chk("oor_up_q", 32'(q), 32'h00);
      chk("oor_up_ovf", 32'(ovf), 32'h1);
      loadb = 0;
      tick("ldf0b");
      loadb = 1; u_db = 0;
      tick("oor_dn");
      chk("oor_dn_q", 32'(q), 32'hEF);

      // Clear loses to set on a TC edge
      loadb = 0; a = 8'h00;
      tick("ld0");
      loadb = 1; clrflgb = 0;
      tick("clr_tc");
      chk("clr_tc_q", 32'(q), 32'd9);
      chk("clr_tc_ovf", 32'(ovf), 32'h1);
      clrflgb = 1;

      // LIMIT=0 up: always terminal
      limit = 8'd0; u_db = 1;
      tick("lim0a");
      tick("lim0b");
      chk("lim0_q", 32'(q), 32'd0);
      satb = 0;
      tick("lim0c");
      chk("lim0_sat_q", 32'(q), 32'd0);
      chk("lim0_ovf", 32'(ovf), 32'h1);

      // Full-range modulo wrap
      limit = 8'hFF; satb = 1; loadb = 0; a = 8'hFF;
      tick("ldff");
      loadb = 1;
      tick("modwrap");
      chk("modwrap_q", 32'(q), 32'h00);
      enpb = 1;

      // Cascade of two 4-bit stages
      c_loadb = 0; c_a = 8'h0F;
      @(posedge clk); #1;
      c_loadb = 1; c_enpb = 0;
      @(posedge clk); #1;
      chk("casc_0f", 32'({hi_q, lo_q}), 32'h10);
      c_loadb = 0; c_a = 8'hFF;
      @(posedge clk); #1;
      c_loadb = 1;
      @(posedge clk); #1;
      chk("casc_ff", 32'({hi_q, lo_q}), 32'h00);
      chk("casc_ovf", 32'({hi_ovf, lo_ovf}), 32'h3);
      c_loadb = 0; c_a = 8'h10;
      @(posedge clk); #1;
      c_loadb = 1; c_udb = 0;
      @(posedge clk); #1;
      chk("casc_dn", 32'({hi_q, lo_q}), 32'h0F);
      c_enpb = 1;
      // Main DUT model stays in step: it only held during the cascade edges
      m_q = int'(q);
      chk("casc_main_hold", 32'(q), 32'h00);

      // Random phase
      for (int i = 0; i < 400; i++) begin
         rstb    = ($urandom_range(0, 49) != 0);
         loadb   = ($urandom_range(0, 7) != 0);
         enpb    = ($urandom_range(0, 4) == 0);
         entb    = ($urandom_range(0, 4) == 0);
         u_db    = ($urandom_range(0, 2) != 0);
         satb    = $urandom_range(0, 1);
         clrflgb = ($urandom_range(0, 5) != 0);
         a       = 8'($urandom);
         if (i % 50 == 0) limit = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
